// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_LOAD    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;

endpackage

// File: rtl/dm_responder_byte_merge.sv
// Byte-lane write merge: enabled lanes come from wdata, the rest from the old word.
module byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byteen_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byteen_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: latency-controlled word array with byte-lane stores,
// pipeline stall generation and a one-cycle store-commit log record.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_data_req,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_pc,
  output logic [31:0] m_data_rdata,
  output logic        m_data_ready,
  output logic        stall,
  output logic        addr_err,
  output logic        w_log_valid,
  output logic [31:0] w_log_pc,
  output logic [31:0] w_log_addr,
  output logic [31:0] w_log_data
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, wdata_q, pc_q;
  logic [3:0]              be_q;
  logic [31:0]             mem_q [DEPTH];
  logic [31:0]             rdata_q, log_pc_q, log_addr_q, log_data_q;
  logic                    ready_q, err_q, log_valid_q;

  logic                    accept;
  logic [31:0]             sel_addr, sel_wdata, offset, cur_word, merged;
  logic [3:0]              sel_be;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    in_range, wr_en;

  // The held request of a finished access is still high during its ready cycle; do not re-accept it.
  assign accept = m_data_req & ~ready_q;

  // With LATENCY=1 the write edge is the acceptance edge, so the live request feeds the datapath in IDLE.
  assign sel_addr  = (state_q == IDLE) ? m_data_addr   : addr_q;
  assign sel_wdata = (state_q == IDLE) ? m_data_wdata  : wdata_q;
  assign sel_be    = (state_q == IDLE) ? m_data_byteen : be_q;

  assign offset   = sel_addr - BASE_ADDR;
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign in_range = (offset[31:ADDR_WIDTH+2] == '0);
  assign cur_word = mem_q[idx];

  byte_merge u_merge (
    .old_i    (cur_word),
    .wdata_i  (sel_wdata),
    .byteen_i (sel_be),
    .merged_o (merged)
  );

  assign wr_en = (state_d == RESP) && (state_q != RESP) && in_range && (sel_be != BE_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers are loaded while in RESP, so the ready pulse lands LATENCY+1 cycles after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      pc_q        <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      log_valid_q <= 1'b0;
      log_pc_q    <= '0;
      log_addr_q  <= '0;
      log_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_q == RESP);
      err_q       <= (state_q == RESP) && !in_range;
      log_valid_q <= (state_q == RESP) && in_range && (be_q != BE_LOAD);
      if (state_q == IDLE && accept) begin
        addr_q  <= m_data_addr;
        wdata_q <= m_data_wdata;
        be_q    <= m_data_byteen;
        pc_q    <= m_inst_pc;
      end
      if (state_q == RESP) begin
        rdata_q <= in_range ? cur_word : '0;
        if (in_range && (be_q != BE_LOAD)) begin
          log_pc_q   <= pc_q;
          log_addr_q <= {addr_q[31:2], 2'b00};
          log_data_q <= cur_word;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  assign m_data_rdata = rdata_q;
  assign m_data_ready = ready_q;
  assign stall        = m_data_req & ~ready_q;
  assign addr_err     = err_q;
  assign w_log_valid  = log_valid_q;
  assign w_log_pc     = log_pc_q;
  assign w_log_addr   = log_addr_q;
  assign w_log_data   = log_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, multi-cycle corner
// sequences and randomized accesses against a word-array reference model.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned LAT   = 2;
  localparam int unsigned LAT_B = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req;
  logic [31:0] addr, wdata, pc;
  logic [3:0]  be;
  logic [31:0] rdata, log_pc, log_addr, log_data;
  logic        ready, stall, err, log_valid;

  logic        rst_b, req_b;
  logic [31:0] addr_b, wdata_b, pc_b;
  logic [3:0]  be_b;
  logic [31:0] rdata_b, log_pc_b, log_addr_b, log_data_b;
  logic        ready_b, stall_b, err_b, log_valid_b;

  dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .m_data_req(req), .m_data_addr(addr), .m_data_wdata(wdata),
    .m_data_byteen(be), .m_inst_pc(pc), .m_data_rdata(rdata), .m_data_ready(ready),
    .stall(stall), .addr_err(err), .w_log_valid(log_valid), .w_log_pc(log_pc),
    .w_log_addr(log_addr), .w_log_data(log_data)
  );

  dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst(rst_b), .m_data_req(req_b), .m_data_addr(addr_b), .m_data_wdata(wdata_b),
    .m_data_byteen(be_b), .m_inst_pc(pc_b), .m_data_rdata(rdata_b), .m_data_ready(ready_b),
    .stall(stall_b), .addr_err(err_b), .w_log_valid(log_valid_b), .w_log_pc(log_pc_b),
    .w_log_addr(log_addr_b), .w_log_data(log_data_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: flat word array, lane mask arithmetic.
  logic [31:0] model_mem [DEPTH];

  function automatic void model_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                                       output logic [31:0] rd, output logic e, output logic lv);
    logic [31:0] off, mask, w;
    off = a - BASE;
    if (off >= 32'(4 * DEPTH)) begin
      rd = '0; e = 1'b1; lv = 1'b0;
    end else begin
      mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      w = model_mem[off / 4];
      w = (w & ~mask) | (wd & mask);
      model_mem[off / 4] = w;
      rd = w; e = 1'b0; lv = (b != 4'b0000);
    end
  endfunction

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b, input logic [31:0] p,
                        output logic [31:0] rd, output logic e, output logic lv,
                        output logic [31:0] lpc, output logic [31:0] laddr, output logic [31:0] ldata,
                        output int rdy_cyc, output int stall_cyc);
    req = 1'b1; addr = a; wdata = wd; be = b; pc = p;
    rdy_cyc = -1; stall_cyc = 0;
    rd = '0; e = 1'b0; lv = 1'b0; lpc = '0; laddr = '0; ldata = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall) stall_cyc++;
      if (ready) begin
        rdy_cyc = c; rd = rdata; e = err; lv = log_valid;
        lpc = log_pc; laddr = log_addr; ldata = log_data;
        break;
      end
      @(posedge clk); #1;
    end
    if (rdy_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no ready for addr %h", a);
    end
    @(posedge clk); #1;
    req = 1'b0;
    check("pulse_ready", {31'b0, ready}, 32'd0);
    check("pulse_log", {31'b0, log_valid}, 32'd0);
  endtask

  task automatic exercise(input string tag, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                          input logic [31:0] p, input logic [31:0] exp_rd, input logic exp_err, input logic exp_lv);
    logic [31:0] rd, lpc, laddr, ldata;
    logic e, lv;
    int rc, sc;
    access(a, wd, b, p, rd, e, lv, lpc, laddr, ldata, rc, sc);
    check({tag, ".ready_cycle"}, rc, LAT + 1);
    check({tag, ".stall_cycles"}, sc, LAT + 1);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".addr_err"}, {31'b0, e}, {31'b0, exp_err});
    check({tag, ".log_valid"}, {31'b0, lv}, {31'b0, exp_lv});
    if (exp_lv) begin
      check({tag, ".log_pc"}, lpc, p);
      check({tag, ".log_addr"}, laddr, {a[31:2], 2'b00});
      check({tag, ".log_data"}, ldata, exp_rd);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        err;
    logic        lv;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] mrd, ra, rwd, rpc, rd, lpc, laddr, ldata;
    logic        merr, mlv, e, lv, seen;
    logic [3:0]  rbe;
    int          cyc, sc;

    for (int unsigned i = 0; i < DEPTH; i++) model_mem[i] = '0;

    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, BE_LOAD,    32'h1000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0010, 32'hDEAD_BEEF, BE_WORD,    32'h1004, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_0010, 32'h0000_0000, BE_LOAD,    32'h1008, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0012, 32'h0055_0000, BE_B2,      32'h100C, 32'hDE55_BEEF, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0012, 32'h1234_0000, BE_HALF_HI, 32'h1010, 32'h1234_BEEF, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000_0013, 32'hFFFF_FFFF, BE_LOAD,    32'h1014, 32'h1234_BEEF, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_4000, 32'hCAFE_F00D, BE_WORD,    32'h1018, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, BE_LOAD,    32'h101C, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_4000, 32'h0000_0000, BE_LOAD,    32'h1020, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_3FFC, 32'hA5A5_A5A5, BE_WORD,    32'h1024, 32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_3FFC, 32'h0000_0000, BE_LOAD,    32'h1028, 32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0009, 32'h1122_7744, BE_B1,      32'h102C, 32'h0000_7700, 1'b0, 1'b1};
    vecs[12] = '{32'hFFFF_FFFC, 32'h0000_00AA, BE_B0,      32'h1030, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1; req = 1'b0; addr = '0; wdata = '0; be = '0; pc = '0;
    rst_b = 1'b1; req_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0; pc_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, ready}, 32'd0);
    check("rst.addr_err", {31'b0, err}, 32'd0);
    check("rst.log_valid", {31'b0, log_valid}, 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.log_pc", log_pc, 32'd0);
    check("rst.log_addr", log_addr, 32'd0);
    check("rst.log_data", log_data, 32'd0);
    req = 1'b1; #1;
    check("rst.stall_follows_req_hi", {31'b0, stall}, 32'd1);
    req = 1'b0; #1;
    check("rst.stall_follows_req_lo", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      model_access(vecs[i].addr, vecs[i].wdata, vecs[i].be, mrd, merr, mlv);
      exercise($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].pc,
               vecs[i].rd, vecs[i].err, vecs[i].lv);
    end

    // Request dropped during WAIT: the access still completes and commits
    req = 1'b1; addr = 32'h40; wdata = 32'h1122_3344; be = BE_WORD; pc = 32'h2000;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = -1; lv = 1'b0; ldata = '0;
    for (int c = 1; c < 40; c++) begin
      #1;
      if (ready) begin cyc = c; lv = log_valid; ldata = log_data; break; end
      @(posedge clk); #1;
    end
    check("drop.ready_cycle", cyc, LAT + 1);
    check("drop.log_valid", {31'b0, lv}, 32'd1);
    check("drop.log_data", ldata, 32'h1122_3344);
    @(posedge clk); #1;
    model_access(32'h40, 32'h1122_3344, BE_WORD, mrd, merr, mlv);
    exercise("drop.readback", 32'h40, 32'h0, BE_LOAD, 32'h2004, 32'h1122_3344, 1'b0, 1'b0);

    // Randomized accesses against the reference model
    for (int k = 0; k < 150; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 8)       ra = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      else if (kind == 8) ra = 32'h3FF0 + $urandom_range(0, 31);
      else                ra = $urandom;
      rwd = $urandom;
      rbe = ($urandom_range(0, 2) == 0) ? BE_LOAD : 4'($urandom_range(0, 15));
      rpc = 32'h8000 + 32'(k * 4);
      model_access(ra, rwd, rbe, mrd, merr, mlv);
      exercise($sformatf("rand%0d", k), ra, rwd, rbe, rpc, mrd, merr, mlv);
    end

    // LATENCY=4 instance: reset during WAIT discards the pending store
    req_b = 1'b1; addr_b = 32'h20; wdata_b = 32'hAABB_CCDD; be_b = BE_WORD; pc_b = 32'h3000;
    seen = 1'b0;
    @(posedge clk); #1;
    if (ready_b || log_valid_b) seen = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0; req_b = 1'b0;
    repeat (8) begin
      if (ready_b || log_valid_b) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("b.reset_no_pulse", {31'b0, seen}, 32'd0);

    // Load of the discarded store's word, with LATENCY=4 timing
    req_b = 1'b1; addr_b = 32'h20; be_b = BE_LOAD; wdata_b = '0;
    cyc = -1; sc = 0; rd = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall_b) sc++;
      if (ready_b) begin cyc = c; rd = rdata_b; break; end
      @(posedge clk); #1;
    end
    check("b.ready_cycle", cyc, LAT_B + 1);
    check("b.stall_cycles", sc, LAT_B + 1);
    check("b.rdata_after_reset", rd, 32'h0);
    @(posedge clk); #1;
    req_b = 1'b0;

    // LATENCY=4 store commit
    req_b = 1'b1; addr_b = 32'h24; be_b = BE_HALF_LO; wdata_b = 32'h9999_5A5A; pc_b = 32'h3010;
    cyc = -1; lv = 1'b0; ldata = '0; laddr = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready_b) begin cyc = c; lv = log_valid_b; ldata = log_data_b; laddr = log_addr_b; break; end
      @(posedge clk); #1;
    end
    check("b.store_ready_cycle", cyc, LAT_B + 1);
    check("b.store_log_valid", {31'b0, lv}, 32'd1);
    check("b.store_log_data", ldata, 32'h0000_5A5A);
    check("b.store_log_addr", laddr, 32'h24);
    @(posedge clk); #1;
    req_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
